bus_sram_slave: RTL and testbench

Word-addressed SRAM responder for the CPU bus, acting as the target end of the bus master protocol that the MEM and IF stage bus interfaces drive. It accepts a strobed request qualified by its chip select, inserts a fixed number of wait states, then completes the access with a single-cycle active-low ready. It sits behind the bus chip-select decoder, one instance per address window, and its read data is zero when idle so it can be OR-combined onto the shared read bus.

---
 rtl/bus_sram_slave_pkg.sv | 23 ++
 rtl/bus_sram_array.sv | 25 ++
 rtl/bus_sram_slave.sv | 125 ++++++++++++
 tb/tb_bus_sram_slave.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sram_slave_pkg.sv
// Shared definitions for the bus SRAM responder: state codes, counter width,
// bus polarity constants and the request decode helper.
package bus_sram_slave_pkg;

    localparam int unsigned BUS_SLV_STATE_W = 2;
    localparam int unsigned BUS_SLV_WAIT_W  = 4;
    localparam int unsigned WORD_DATA_W     = 32;

    localparam logic [BUS_SLV_STATE_W-1:0] BUS_SLV_IDLE = 2'd0;
    localparam logic [BUS_SLV_STATE_W-1:0] BUS_SLV_WAIT = 2'd1;
    localparam logic [BUS_SLV_STATE_W-1:0] BUS_SLV_RESP = 2'd2;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // A request needs both the window select and the master strobe asserted.
    function automatic logic bus_request(input logic cs_n, input logic as_n);
        return (cs_n == ENABLE_) && (as_n == ENABLE_);
    endfunction

endpackage

// File: rtl/bus_sram_array.sv
// Single-port synchronous word RAM, read-first, inferable as block RAM.
// Ports: clk, we (write enable), addr (word address), wr_data, rd_data
// (registered read of the word at addr from the previous edge).
// Contents are not reset.
module bus_sram_array #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
        rd_data <= mem[addr];
    end

endmodule

// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM target for the CPU bus. Accepts a request qualified by
// cs_/as_, optionally inserts WAIT_CYCLES wait states, then completes with a
// one-cycle active-low rdy_. rd_data is zero outside the ready cycle so it can
// be OR-combined onto the shared read bus.
// Ports: clk; reset (sync, active-low); cs_, as_ (active-low select/strobe);
// rw (1 = read, 0 = write); addr (word address); wr_data; rd_data; rdy_.
// Build option: define BUS_SRAM_WAIT_EN to compile in the WAIT state and the
// wait counter; otherwise every access completes one cycle after acceptance.
module bus_sram_slave
    import bus_sram_slave_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs_,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   rdy_
);

    if (WAIT_CYCLES > 15) begin : g_wait_range
        $error("WAIT_CYCLES must be in 0..15");
    end

    logic [BUS_SLV_STATE_W-1:0] state;
    logic [BUS_SLV_STATE_W-1:0] state_nxt;
    logic                       req;
    logic                       rw_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [WORD_DATA_W-1:0]     wr_data_q;
    logic                       ram_we;
    logic [ADDR_W-1:0]          ram_addr;
    logic [WORD_DATA_W-1:0]     ram_q;

`ifdef BUS_SRAM_WAIT_EN
    logic [BUS_SLV_WAIT_W-1:0]  cnt;
    logic [BUS_SLV_WAIT_W-1:0]  cnt_nxt;
`endif

    assign req = bus_request(cs_, as_);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
`ifdef BUS_SRAM_WAIT_EN
        cnt_nxt   = cnt;
`endif
        case (state)
            BUS_SLV_IDLE: begin
                if (req) begin
`ifdef BUS_SRAM_WAIT_EN
                    cnt_nxt   = BUS_SLV_WAIT_W'(WAIT_CYCLES);
                    state_nxt = (WAIT_CYCLES == 0) ? BUS_SLV_RESP : BUS_SLV_WAIT;
`else
                    state_nxt = BUS_SLV_RESP;
`endif
                end
            end
`ifdef BUS_SRAM_WAIT_EN
            BUS_SLV_WAIT: begin
                // Master withdrawing the request cancels the access outright.
                cnt_nxt = cnt - BUS_SLV_WAIT_W'(1);
                if (!req) begin
                    state_nxt = BUS_SLV_IDLE;
                end else if (cnt == BUS_SLV_WAIT_W'(1)) begin
                    state_nxt = BUS_SLV_RESP;
                end
            end
`endif
            BUS_SLV_RESP: state_nxt = BUS_SLV_IDLE;
            default:      state_nxt = BUS_SLV_IDLE;
        endcase
    end

    // State, request latches and registered ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= BUS_SLV_IDLE;
            rdy_      <= DISABLE_;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
`ifdef BUS_SRAM_WAIT_EN
            cnt       <= '0;
`endif
        end else begin
            state <= state_nxt;
            rdy_  <= (state_nxt == BUS_SLV_RESP) ? ENABLE_ : DISABLE_;
`ifdef BUS_SRAM_WAIT_EN
            cnt   <= cnt_nxt;
`endif
            if ((state == BUS_SLV_IDLE) && req) begin
                rw_q      <= rw;
                addr_q    <= addr;
                wr_data_q <= wr_data;
            end
        end
    end

    // The RAM sees the live bus address while idle so a zero-wait access has
    // its read word ready on RESP entry; afterwards it follows the latch.
    assign ram_addr = (state == BUS_SLV_IDLE) ? addr : addr_q;
    // Reset low at the RESP edge suppresses the pending write.
    assign ram_we   = (state == BUS_SLV_RESP) && (rw_q == WRITE) && reset;

    bus_sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_DATA_W)
    ) u_array (
        .clk     (clk),
        .we      (ram_we),
        .addr    (ram_addr),
        .wr_data (wr_data_q),
        .rd_data (ram_q)
    );

    // Drive the read bus only during a read's ready cycle.
    assign rd_data = ((rdy_ == ENABLE_) && (rw_q == READ)) ? ram_q : '0;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Scoreboard bench for bus_sram_slave: a master model issues directed and
// random accesses, pushing the expected ready cycle and read data; a monitor
// on the falling edge pops and compares whenever rdy_ is low.
module tb_bus_sram_slave;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned WAIT_CYCLES = 2;
`ifdef BUS_SRAM_WAIT_EN
    localparam int unsigned LAT = WAIT_CYCLES + 1;
`else
    localparam int unsigned LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              cs_;
    logic              as_;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wr_data;
    logic [31:0]       rd_data;
    logic              rdy_;

    typedef struct {
        int unsigned cyc;
        bit          chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [1024];
    bit          vld [1024];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          prev_low = 1'b0;

    bus_sram_slave #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rdy_    (rdy_)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every ready pulse against the scoreboard head.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_rdy %s: no rdy_ seen, required in cycle %0d", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (rdy_ === 1'b0) begin
            n_cmp++;
            if (prev_low) begin
                n_err++;
                $display("FAIL double_rdy: rdy_ low two cycles in a row at cycle %0d", cyc);
            end
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rdy: rdy_ low at cycle %0d with nothing pending", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL rdy_cycle %s: got cycle %0d, required %0d", e.name, cyc, e.cyc);
                end
                if (e.chk) begin
                    n_cmp++;
                    if (rd_data !== e.data) begin
                        n_err++;
                        $display("FAIL rd_data %s: got %h, required %h", e.name, rd_data, e.data);
                    end
                end
            end
            prev_low = 1'b1;
        end else begin
            n_cmp++;
            if (rdy_ !== 1'b1 || rd_data !== 32'h0) begin
                n_err++;
                $display("FAIL idle_bus at cycle %0d: rdy_=%b rd_data=%h, required rdy_=1 rd_data=0", cyc, rdy_, rd_data);
            end
            prev_low = 1'b0;
        end
    end

    // One master access; returns in the ready cycle with the strobe still low
    // (or in the first wait cycle after withdrawing it when aborting).
    task automatic access(input logic r, input int unsigned a, input logic [31:0] d,
                          input bit abort_req, input string nm);
        exp_t e;
        bit   aborted;
        @(posedge clk);
        #1;
        cs_     = 1'b0;
        as_     = 1'b0;
        rw      = r;
        addr    = ADDR_W'(a);
        wr_data = d;
        aborted = abort_req && (LAT > 1);
        if (aborted) begin
            @(posedge clk);
            #1;
            as_ = 1'b1;
        end else begin
            e.cyc  = cyc + LAT;
            e.name = nm;
            e.chk  = (r == 1'b1) && vld[a];
            e.data = mem[a];
            if (r == 1'b0) begin
                mem[a] = d;
                vld[a] = 1'b1;
            end
            sb.push_back(e);
            repeat (LAT) @(posedge clk);
            #1;
        end
    endtask

    // Bus idle for this window; other windows' strobes toggle randomly.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cs_     = 1'b1;
            as_     = 1'($urandom_range(0, 1));
            rw      = 1'($urandom_range(0, 1));
            addr    = ADDR_W'($urandom);
            wr_data = $urandom;
        end
    endtask

    // Reset held for n edges while a write request is presented.
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cs_     = 1'b0;
        as_     = 1'b0;
        rw      = 1'b0;
        addr    = ADDR_W'(5);
        wr_data = 32'hBAD0_BAD0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        cs_   = 1'b1;
        as_   = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        cs_     = 1'b0;
        as_     = 1'b0;
        rw      = 1'b0;
        addr    = ADDR_W'(5);
        wr_data = 32'hBAD0_BAD0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        cs_   = 1'b1;
        as_   = 1'b1;
        idle(2);

        access(1'b0, 5, 32'hDEAD_BEEF, 1'b0, "wr_deadbeef");
        idle(1);
        access(1'b1, 5, 32'h0, 1'b0, "rd_deadbeef");
        idle(2);

        // Strobe for another window must not touch this one.
        repeat (10) begin
            @(posedge clk);
            #1;
            cs_     = 1'b1;
            as_     = 1'b0;
            rw      = 1'b0;
            addr    = ADDR_W'(5);
            wr_data = 32'hFFFF_FFFF;
        end
        idle(1);
        access(1'b1, 5, 32'h0, 1'b0, "rd_after_cs_gate");
        idle(1);

        access(1'b0, 6, 32'h0BAD_F00D, 1'b0, "wr_prior_6");
        idle(1);
        access(1'b0, 6, 32'h1234_5678, 1'b1, "wr_abort_6");
        idle(1);
        access(1'b1, 6, 32'h0, 1'b0, "rd_after_abort");
        idle(1);

        do_reset(3);
        idle(1);
        access(1'b1, 5, 32'h0, 1'b0, "rd_after_reset");
        idle(1);

        for (int i = 0; i < 4; i++) begin
            access(1'b0, i, 32'hA5A5_0000 + 32'(i * 17), 1'b0, "wr_b2b_setup");
            idle(1);
        end
        for (int i = 0; i < 4; i++) begin
            access(1'b1, i, 32'h0, 1'b0, "rd_b2b");
        end
        idle(1);

        for (int i = 0; i < 60; i++) begin
            int unsigned gap;
            access(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                   ($urandom_range(0, 7) == 0), "random");
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(int'(gap));
        end
        idle(int'(LAT) + 4);

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
